arch_map_table: RTL
===================

# arch_map_table

Committed (architectural) register map for the out-of-order core. It takes up to RETIRE_WIDTH in-order retirements per cycle from the ROB and updates the arch-to-phys mapping. It returns each displaced physical tag to the free list one cycle later. On a retired mispredict it streams the committed map to the rename map table over several cycles, stalling retirement until the stream ends.

## Interface
Parameters:
- ARCH_REGS, 32, number of architectural registers; must be a multiple of BCAST_WIDTH.
- PHYS_REGS, 64, number of physical registers; TAG_W = $clog2(PHYS_REGS).
- RETIRE_WIDTH, 3, retire slots per cycle; slot 0 is oldest.
- BCAST_WIDTH, 8, map entries broadcast per recovery beat; IDX_W = $clog2(ARCH_REGS).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- retire_valid  in  RETIRE_WIDTH  slot i holds a retiring instruction.
- retire_arch_idx  in  RETIRE_WIDTH x IDX_W  destination arch register.
- retire_phys_tag  in  RETIRE_WIDTH x TAG_W  destination physical tag.
- retire_mispredict  in  RETIRE_WIDTH  slot i is a mispredicted branch.
- retire_uncond  in  RETIRE_WIDTH  slot i is an unconditional jump that writes a link register.
- retire_ready  out  1  map accepts retirements this cycle.
- freed_valid  out  RETIRE_WIDTH  registered; freed_tag[i] is valid.
- freed_tag  out  RETIRE_WIDTH x TAG_W  displaced physical tag, to the free list.
- recover_valid  out  1  recovery beat valid.
- recover_base  out  IDX_W  first arch index of this beat, = beat x BCAST_WIDTH.
- recover_tags  out  BCAST_WIDTH x TAG_W  map[recover_base + k], k = 0..BCAST_WIDTH-1.
- recover_last  out  1  final beat of the recovery stream.

## Operation
- State: map[ARCH_REGS] of TAG_W bits; FSM {IDLE, BCAST}; beat counter of $clog2(ARCH_REGS/BCAST_WIDTH) bits (minimum 1).
- retire_ready = (state == IDLE). While it is low, all retire inputs are ignored.
- Slot commit rule in IDLE: slot i commits when retire_valid[i] is set and every slot j < i committed and was not a mispredict. Slot 0 needs only retire_valid[0].
- A committed slot with retire_mispredict set ends the group; younger slots are discarded.
- A mispredicting slot writes the map only when retire_uncond is set; a conditional mispredict performs no write.
- Writes to arch index 0 are suppressed and produce no freed tag.
- A writing slot sets map[idx] = tag and frees the previous mapping of idx.
- Intra-group forwarding: if an older committed slot in the same cycle wrote the same idx, the freed tag is that older slot's tag, not the registered value. The youngest writer wins the final map value.
- Recovery trigger: any committed slot has retire_mispredict set. At the edge, the map update applies, state becomes BCAST and the beat counter clears to 0.
- BCAST: each cycle drives recover_valid=1, recover_base = beat x BCAST_WIDTH and recover_tags from the registered map. The counter increments each cycle.
- On the last beat (beat == ARCH_REGS/BCAST_WIDTH - 1), recover_last=1 and the next state is IDLE.
- The map is constant throughout BCAST.

## Timing
- Reset (asserted low, asynchronous): map[i] = i; state IDLE; beat 0; freed_valid all 0; freed_tag 0.
- Outputs after reset: recover_valid 0; recover_last 0; recover_base 0; retire_ready 1.
- Map update takes effect on the edge after retire. Reads in the following cycle see the new value.
- freed_valid and freed_tag are registered and appear exactly 1 cycle after the retire cycle; otherwise freed_valid is 0.
- Recovery: first beat in the cycle after the mispredict retire. Stream length is ARCH_REGS/BCAST_WIDTH cycles; 4 with the defaults.
- retire_ready is low for exactly that many cycles, and high again in the cycle after recover_last.
- recover_base, recover_tags, recover_valid and recover_last are combinational from registered state (no input-to-output path). recover_tags is 0 when not valid.
- Reset asserted mid-stream aborts it immediately: recover_valid drops asynchronously and the map reinitialises.
- Back-to-back mispredicts cannot occur, because retirement is blocked during BCAST.

## Test plan
- Reset, then retire slot0 {idx 5, tag 40} -> next cycle freed_valid=001, freed_tag[0]=5; then map[5]=40.
- One cycle: slot0 {idx 3, tag 50}, slot1 {idx 3, tag 51}, slot2 {idx 0, tag 52} -> freed_tag[0]=3, freed_tag[1]=50, freed_valid=011; map[3]=51; map[0] stays 0.
- Slot0 {idx 7, tag 45}, slot1 conditional mispredict, slot2 {idx 8, tag 46} -> map[7]=45, map[8]=8, freed_valid=001.
- Recovery beats then follow: recover_valid high for 4 cycles, recover_base 0, 8, 16, 24, recover_last on the 4th beat; retire_ready low over those 4 cycles.
- Slot0 uncond mispredict {idx 1, tag 60} -> map[1]=60, freed_tag[0]=1. Beat 0 shows recover_tags[1]=60. Retire inputs held valid during BCAST are ignored, leaving the map unchanged.
- Assert reset low during beat 2 -> recover_valid 0 immediately; map back to identity; retire_ready 1 after reset is deasserted.

Source files
------------

// File: rtl/arch_map_table.sv
// arch_map_table: committed arch-to-phys register map.
// Retires in-order groups, frees displaced tags, streams map on mispredict.
module arch_map_table #(
    parameter int ARCH_REGS    = 32,
    parameter int PHYS_REGS    = 64,
    parameter int RETIRE_WIDTH = 3,
    parameter int BCAST_WIDTH  = 8,
    localparam int TAG_W       = $clog2(PHYS_REGS),
    localparam int IDX_W       = $clog2(ARCH_REGS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [RETIRE_WIDTH-1:0]         retire_valid,
    input  logic [RETIRE_WIDTH*IDX_W-1:0]   retire_arch_idx,
    input  logic [RETIRE_WIDTH*TAG_W-1:0]   retire_phys_tag,
    input  logic [RETIRE_WIDTH-1:0]         retire_mispredict,
    input  logic [RETIRE_WIDTH-1:0]         retire_uncond,
    output logic                            retire_ready,
    output logic [RETIRE_WIDTH-1:0]         freed_valid,
    output logic [RETIRE_WIDTH*TAG_W-1:0]   freed_tag,
    output logic                            recover_valid,
    output logic [IDX_W-1:0]                recover_base,
    output logic [BCAST_WIDTH*TAG_W-1:0]    recover_tags,
    output logic                            recover_last
);

    localparam int BEATS = ARCH_REGS / BCAST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BCAST = 1'b1;

    logic [TAG_W-1:0]              map_q [ARCH_REGS];
    logic [TAG_W-1:0]              map_d [ARCH_REGS];
    logic [0:0]                    state_q, state_d;
    logic [CNT_W-1:0]              beat_q, beat_d;
    logic [RETIRE_WIDTH-1:0]       freed_valid_q, freed_valid_d;
    logic [RETIRE_WIDTH*TAG_W-1:0] freed_tag_q, freed_tag_d;

    logic             alive;
    logic             mispred_hit;
    logic [IDX_W-1:0] s_idx;
    logic [TAG_W-1:0] s_tag;

    assign retire_ready = (state_q == S_IDLE);

    // Retire group walk; map_d is updated slot by slot so younger slots
    // see older writers (forwarding) and the youngest writer wins.
    always_comb begin
        map_d         = map_q;
        state_d       = state_q;
        beat_d        = beat_q;
        freed_valid_d = '0;
        freed_tag_d   = '0;
        alive         = (state_q == S_IDLE);
        mispred_hit   = 1'b0;
        s_idx         = '0;
        s_tag         = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            s_idx = retire_arch_idx[i*IDX_W +: IDX_W];
            s_tag = retire_phys_tag[i*TAG_W +: TAG_W];
            if (alive && retire_valid[i]) begin
                if ((!retire_mispredict[i] || retire_uncond[i]) &&
                    (s_idx != '0)) begin
                    freed_valid_d[i]             = 1'b1;
                    freed_tag_d[i*TAG_W +: TAG_W] = map_d[s_idx];
                    map_d[s_idx]                 = s_tag;
                end
                if (retire_mispredict[i]) begin
                    mispred_hit = 1'b1;
                    alive       = 1'b0;
                end
            end else begin
                alive = 1'b0;
            end
        end
        if (state_q == S_IDLE) begin
            if (mispred_hit) begin
                state_d = S_BCAST;
                beat_d  = '0;
            end
        end else begin
            if (beat_q == CNT_W'(BEATS - 1)) begin
                state_d = S_IDLE;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // State registers; reset restores the identity map.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= TAG_W'(i);
            end
            state_q       <= S_IDLE;
            beat_q        <= '0;
            freed_valid_q <= '0;
            freed_tag_q   <= '0;
        end else begin
            map_q         <= map_d;
            state_q       <= state_d;
            beat_q        <= beat_d;
            freed_valid_q <= freed_valid_d;
            freed_tag_q   <= freed_tag_d;
        end
    end

    assign freed_valid   = freed_valid_q;
    assign freed_tag     = freed_tag_q;
    assign recover_valid = (state_q == S_BCAST);
    assign recover_base  = IDX_W'(int'(beat_q) * BCAST_WIDTH);
    assign recover_last  = recover_valid &&
                           (beat_q == CNT_W'(BEATS - 1));

    // Recovery beat payload read from the registered map.
    always_comb begin
        recover_tags = '0;
        if (recover_valid) begin
            for (int k = 0; k < BCAST_WIDTH; k++) begin
                recover_tags[k*TAG_W +: TAG_W] =
                    map_q[recover_base + IDX_W'(k)];
            end
        end
    end

endmodule
